// File: rtl/led_uart_dump.sv
// led_uart_dump: serialises the CPU LED state over an 8N1 UART line.
// Each frame is three bytes: 0xA5 sync, {0000,ledfpga}, {00,ledregfpga}.
// A frame is sent after reset and whenever the inputs differ from the
// last value sent. Changes made while a frame or gap is in progress are
// coalesced, so only the value present on return to idle is compared.
module led_uart_dump #(
   parameter int CLKS_PER_BIT = 868,
   parameter int GAP_BITS     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ledfpga,
   input  logic [5:0] ledregfpga,
   output logic       uart_tx,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [3:0]       gap_idx;
   logic [9:0]       last_sent;
   logic             first_pending;

   logic [9:0]       cur_leds;
   logic             trigger;
   logic             baud_end;
   logic [7:0]       cur_byte;

   assign cur_leds = {ledfpga, ledregfpga};
   assign trigger  = first_pending || (cur_leds != last_sent);
   assign baud_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // Byte currently on the wire, always taken from the snapshot so input
   // changes during a frame never reach the bytes in flight.
   always_comb begin
      cur_byte = 8'hA5;
      case (byte_idx)
         2'd0:    cur_byte = 8'hA5;
         2'd1:    cur_byte = {4'b0000, last_sent[9:6]};
         2'd2:    cur_byte = {2'b00, last_sent[5:0]};
         default: cur_byte = 8'hA5;
      endcase
   end

   // Transmit FSM: baud timing, bit/byte sequencing, gap and frame count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         baud_cnt      <= '0;
         bit_idx       <= '0;
         byte_idx      <= '0;
         gap_idx       <= '0;
         last_sent     <= '0;
         first_pending <= 1'b1;
         uart_tx       <= 1'b1;
         busy          <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // Start bit goes out on the same edge that takes the snapshot.
               if (trigger) begin
                  last_sent     <= cur_leds;
                  first_pending <= 1'b0;
                  byte_idx      <= '0;
                  bit_idx       <= '0;
                  baud_cnt      <= '0;
                  uart_tx       <= 1'b0;
                  busy          <= 1'b1;
                  state         <= S_START;
               end
            end
            S_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  uart_tx  <= cur_byte[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     uart_tx <= 1'b1;
                     state   <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (byte_idx != 2'd2) begin
                     // Next byte follows the stop bit with no idle time.
                     byte_idx <= byte_idx + 2'd1;
                     uart_tx  <= 1'b0;
                     state    <= S_START;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                     if (GAP_BITS == 0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        gap_idx <= '0;
                        state   <= S_GAP;
                     end
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (gap_idx == 4'(GAP_BITS - 1)) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     gap_idx <= gap_idx + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               uart_tx <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
